// File: rtl/tiny_pkg.sv
// Shared definitions for the instruction-memory loader: NOP fill word, loader state encoding
// and default memory geometry. Optional build macro used by the loader: IMEM_LOADER_SYNC_EN.
package tiny_pkg;

    localparam int          ADDR_BITS_DEFAULT = 4;
    localparam logic [31:0] NOP               = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } ld_state_e;

    // Little-endian word assembly: three buffered low bytes plus the byte arriving now.
    function automatic logic [31:0] pack_word(input logic [23:0] low_bytes, input logic [7:0] top_byte);
        return {top_byte, low_bytes};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host load port plus core fetch port of the instruction-memory loader.
// master = host/core side, slave = loader. Timing of load_en/byte_stb depends on IMEM_LOADER_SYNC_EN.
interface imem_loader_if import tiny_pkg::*; #(
    parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) ();

    logic                 load_en;
    logic [7:0]           byte_in;
    logic                 byte_stb;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [31:0]          rd_data;
    logic                 core_reset;
    logic                 load_done;
    logic [ADDR_BITS:0]   word_count;
    logic                 overflow;

    modport master (
        output load_en, byte_in, byte_stb, rd_addr,
        input  rd_data, core_reset, load_done, word_count, overflow
    );

    modport slave (
        input  load_en, byte_in, byte_stb, rd_addr,
        output rd_data, core_reset, load_done, word_count, overflow
    );

endinterface

// File: rtl/imem_loader_sync_rise.sv
// Two-flop synchronizer with rising-edge detect; used for load_en and byte_stb
// only when IMEM_LOADER_SYNC_EN is defined.
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [2:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= 3'b000;
        end else begin
            sh_q <= {sh_q[1:0], d_i};
        end
    end

    // sh_q[1] is the synchronized level; sh_q[2] is its previous value.
    assign level_o = sh_q[1];
    assign rise_o  = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/imem_loader.sv
// Writable instruction memory fed by a byte-serial host port; holds the core in reset while loading.
// Define IMEM_LOADER_SYNC_EN to synchronize load_en/byte_stb and use byte_stb rising edges as strobes.
module imem_loader import tiny_pkg::*; #(
    parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);

    localparam int                 DEPTH    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);

    logic ld;
    logic stb_evt;

`ifdef IMEM_LOADER_SYNC_EN
    logic stb_level;

    sync_rise u_sync_ld (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.load_en),
        .level_o (ld),
        .rise_o  ()
    );

    sync_rise u_sync_stb (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (bus.byte_stb),
        .level_o (stb_level),
        .rise_o  (stb_evt)
    );
`else
    assign ld      = bus.load_en;
    assign stb_evt = bus.byte_stb;
`endif

    ld_state_e            state_q, state_d;
    logic                 core_reset_q, load_done_q;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [23:0]          asm_q, asm_d;
    logic [ADDR_BITS:0]   wc_q, wc_d;
    logic                 ovf_q, ovf_d;
    logic [31:0]          mem_q [DEPTH];

    logic                 load_entry;
    logic                 accept;
    logic                 full;
    logic                 we;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [31:0]          wr_data;
    logic [DEPTH-1:0]     word_we;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ld ? ST_LOAD : ST_RUN;
            ST_LOAD: if (!ld) state_d = ST_RUN;
            ST_RUN:  if (ld)  state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    assign accept     = (state_q == ST_LOAD) && ld && stb_evt;
    assign full       = (wc_q == FULL_CNT);
    assign we         = accept && !full && (bcnt_q == 2'd3);
    // The word count doubles as the write pointer; writes stop once it reaches DEPTH.
    assign wr_addr    = wc_q[ADDR_BITS-1:0];
    assign wr_data    = pack_word(asm_q, bus.byte_in);

    always_comb begin
        bcnt_d = bcnt_q;
        asm_d  = asm_q;
        wc_d   = wc_q;
        ovf_d  = ovf_q;
        if (load_entry) begin
            bcnt_d = 2'd0;
            asm_d  = 24'd0;
            wc_d   = '0;
            ovf_d  = 1'b0;
        end else if (accept) begin
            if (full) begin
                ovf_d = 1'b1;
            end else if (bcnt_q == 2'd3) begin
                bcnt_d = 2'd0;
                wc_d   = wc_q + (ADDR_BITS + 1)'(1);
            end else begin
                bcnt_d = bcnt_q + 2'd1;
                case (bcnt_q)
                    2'd0:    asm_d[7:0]   = bus.byte_in;
                    2'd1:    asm_d[15:8]  = bus.byte_in;
                    default: asm_d[23:16] = bus.byte_in;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            bcnt_q       <= 2'd0;
            asm_q        <= 24'd0;
            wc_q         <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_reset_q <= (state_d != ST_RUN);
            load_done_q  <= (state_d == ST_RUN);
            bcnt_q       <= bcnt_d;
            asm_q        <= asm_d;
            wc_q         <= wc_d;
            ovf_q        <= ovf_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = we && (wr_addr == ADDR_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_we[i]) begin
                    mem_q[i] <= wr_data;
                end
            end
        end
    end

    assign bus.rd_data    = mem_q[bus.rd_addr];
    assign bus.core_reset = core_reset_q;
    assign bus.load_done  = load_done_q;
    assign bus.word_count = wc_q;
    assign bus.overflow   = ovf_q;

endmodule
